// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - valid/ready pixel or result stream
interface sobel_stream_if #(
  parameter int W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge filter over raster-order frames
module sobel_stream #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = 10,
  parameter int OUT_W     = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       width_i,
  input  logic [15:0]       height_i,
  input  logic [1:0]        mode_i,
  input  logic [OUT_W-1:0]  threshold_i,
  sobel_stream_if.slave     s_axis,
  sobel_stream_if.master    m_axis,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   col_q, col_d, last_col_q, last_col_d;
  logic [15:0]         row_q, row_d, last_row_q, last_row_d;
  logic [1:0]          mode_q, mode_d;
  logic [OUT_W-1:0]    thr_q, thr_d;
  logic                err_q, err_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [OUT_W-1:0]    m_data_q, m_data_d;

  logic [PIX_W-1:0]    line_a_q [MAX_WIDTH];
  logic [PIX_W-1:0]    line_b_q [MAX_WIDTH];
  logic [PIX_W-1:0]    win_q [3][2];
  logic [PIX_W-1:0]    col_pix [3];

  logic                s_ready, xfer, dims_ok, at_last_col;
  logic signed [OUT_W-1:0] p [3][3];
  logic signed [OUT_W-1:0] gx, gy, abs_gx, abs_gy;
  logic [OUT_W-1:0]    mag, result;

  function automatic logic signed [OUT_W-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({{(OUT_W-PIX_W){1'b0}}, v});
  endfunction

  assign dims_ok = (width_i >= 16'd3) && (width_i <= 16'(MAX_WIDTH)) && (height_i >= 16'd3);
  assign s_ready = (state_q == RUN) && (!m_valid_q || m_axis.tready);
  assign xfer    = s_ready && s_axis.tvalid;
  assign at_last_col = (col_q == last_col_q);

  // Incoming column: oldest row from A, middle row from B, newest row is the live pixel.
  always_comb begin
    col_pix[0] = line_a_q[col_q];
    col_pix[1] = line_b_q[col_q];
    col_pix[2] = s_axis.tdata;
    for (int r = 0; r < 3; r++) begin
      p[r][0] = ext(win_q[r][0]);
      p[r][1] = ext(win_q[r][1]);
      p[r][2] = ext(col_pix[r]);
    end
  end

  always_comb begin
    gx = (p[0][0] + p[0][1] + p[0][1] + p[0][2]) - (p[2][0] + p[2][1] + p[2][1] + p[2][2]);
    gy = (p[0][2] + p[1][2] + p[1][2] + p[2][2]) - (p[0][0] + p[1][0] + p[1][0] + p[2][0]);
    abs_gx = gx[OUT_W-1] ? -gx : gx;
    abs_gy = gy[OUT_W-1] ? -gy : gy;
    mag    = abs_gx + abs_gy;
    case (mode_q)
      2'd0:    result = gx;
      2'd1:    result = gy;
      2'd2:    result = mag;
      default: result = (mag >= thr_q) ? {{(OUT_W-PIX_W){1'b0}}, {PIX_W{1'b1}}} : '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    mode_d     = mode_q;
    thr_d      = thr_q;
    err_d      = err_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;

    if (m_valid_q && m_axis.tready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (dims_ok) begin
            last_col_d = width_i[ADDR_W-1:0] - ADDR_W'(1);
            last_row_d = height_i - 16'd1;
            mode_d     = mode_i;
            thr_d      = threshold_i;
            col_d      = '0;
            row_d      = '0;
            err_d      = 1'b0;
            state_d    = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (at_last_col) begin
            col_d = '0;
            row_d = row_q + 16'd1;
            if (row_q == last_row_q) state_d = DONE;
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
          if ((row_q >= 16'd2) && (col_q >= ADDR_W'(2))) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
            m_last_d  = (row_q == last_row_q) && at_last_col;
          end
        end
      end
      DONE: begin
        if (m_valid_q && m_axis.tready && m_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      last_col_q <= '0;
      last_row_q <= '0;
      mode_q     <= '0;
      thr_q      <= '0;
      err_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      err_q      <= err_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

  // Window columns restart at col 0 so a new row never sees the previous row's tail.
  always_ff @(posedge clk_i) begin
    if (xfer) begin
      line_a_q[col_q] <= col_pix[1];
      line_b_q[col_q] <= s_axis.tdata;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= (col_q == '0) ? '0 : win_q[r][1];
        win_q[r][1] <= col_pix[r];
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - directed self-checking bench for sobel_stream
module tb_sobel_stream;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [1:0]  mode;
  logic [11:0] threshold;
  logic        busy;
  logic        err;

  sobel_stream_if #(.W(8))  s_if ();
  sobel_stream_if #(.W(12)) m_if ();

  sobel_stream dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .width_i     (width),
    .height_i    (height),
    .mode_i      (mode),
    .threshold_i (threshold),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  frame [8][8];
  logic [11:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [11:0] model(input int r, input int c, input logic [1:0] md,
                                        input logic [11:0] thr);
    int q [3][3];
    int gx, gy, mag;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        q[i][j] = int'(frame[r-1+i][c-1+j]);
    gx = (q[0][0] + 2*q[0][1] + q[0][2]) - (q[2][0] + 2*q[2][1] + q[2][2]);
    gy = (q[0][2] + 2*q[1][2] + q[2][2]) - (q[0][0] + 2*q[1][0] + q[2][0]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (md)
      2'd0:    return 12'(gx);
      2'd1:    return 12'(gy);
      2'd2:    return 12'(mag);
      default: return (mag >= int'(thr)) ? 12'd255 : 12'd0;
    endcase
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        frame[r][c] = 8'(10*c);
  endtask

  task automatic push_n(input int n, input logic [11:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] md, input logic [11:0] thr,
                           input bit rnd_valid, input bit slow_ready);
    int pix_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    int n;
    bit done = 0;
    bit hold = 0;
    logic [11:0] held = '0;
    n = exp_q.size();
    @(negedge clk);
    start = 1'b1; width = 16'(w); height = 16'(h); mode = md; threshold = thr;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
    while (!done && cyc < 3000) begin
      s_if.tvalid = (pix_idx < w*h) && (!rnd_valid || $urandom_range(0, 1) == 1);
      if (pix_idx < w*h) s_if.tdata = frame[pix_idx / w][pix_idx % w];
      m_if.tready = slow_ready ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (hold && m_if.tvalid) chk("hold_stable", 32'(m_if.tdata), 32'(held));
      if (m_if.tvalid && !m_if.tready) chk("backpressure_sready", 32'(s_if.tready), 32'd0);
      if (m_if.tvalid && m_if.tready) begin
        if (out_idx < n)
          chk($sformatf("data[%0d]", out_idx), 32'(m_if.tdata), 32'(exp_q[out_idx]));
        chk($sformatf("last[%0d]", out_idx), 32'(m_if.tlast), 32'(out_idx == n-1));
        out_idx++;
        if (m_if.tlast) done = 1;
      end
      hold = m_if.tvalid && !m_if.tready;
      held = m_if.tdata;
      if (s_if.tvalid && s_if.tready) pix_idx++;
      cyc++;
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    chk("frame_results", 32'(out_idx), 32'(n));
    chk("pixels_taken", 32'(pix_idx), 32'(w*h));
    @(negedge clk);
    chk("busy_cleared", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_s_ready"}, 32'(s_if.tready), 32'd0);
    chk({pfx, "_m_valid"}, 32'(m_if.tvalid), 32'd0);
    chk({pfx, "_m_last"},  32'(m_if.tlast),  32'd0);
    chk({pfx, "_m_data"},  32'(m_if.tdata),  32'd0);
    chk({pfx, "_busy"},    32'(busy),        32'd0);
    chk({pfx, "_err"},     32'(err),         32'd0);
  endtask

  initial begin
    int cnt;
    int cyc;
    rst = 1'b1; start = 1'b0; width = '0; height = '0; mode = '0; threshold = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Horizontal ramp: rows identical so Gx is 0, Gy is 4*20 everywhere.
    fill_ramp();
    push_n(4, 12'd0);
    run_frame(4, 4, 2'd0, 12'd0, 0, 0);
    push_n(4, 12'd80);
    run_frame(4, 4, 2'd1, 12'd0, 0, 0);

    // Step edge between rows 1 and 2: |Gx| = 4*255.
    for (int c = 0; c < 5; c++) begin
      frame[0][c] = 8'd0; frame[1][c] = 8'd0; frame[2][c] = 8'd255;
    end
    push_n(3, 12'd1020);
    run_frame(5, 3, 2'd2, 12'd0, 0, 0);
    push_n(3, 12'd0);
    run_frame(5, 3, 2'd3, 12'd1021, 0, 0);
    push_n(3, 12'd255);
    run_frame(5, 3, 2'd3, 12'd1020, 0, 0);

    // Random frame under random source stalls and sparse sink ready.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        frame[r][c] = 8'($urandom_range(0, 255));
    for (int r = 1; r < 3; r++)
      for (int c = 1; c < 5; c++)
        exp_q.push_back(model(r, c, 2'd0, 12'd0));
    run_frame(6, 4, 2'd0, 12'd0, 1, 1);
    for (int r = 1; r < 3; r++)
      for (int c = 1; c < 5; c++)
        exp_q.push_back(model(r, c, 2'd2, 12'd0));
    run_frame(6, 4, 2'd2, 12'd0, 1, 1);

    // Illegal dimensions.
    @(negedge clk);
    start = 1'b1; width = 16'd2; height = 16'd4;
    @(negedge clk);
    start = 1'b0;
    chk("narrow_err", 32'(err), 32'd1);
    chk("narrow_busy", 32'(busy), 32'd0);
    start = 1'b1; width = 16'd1025; height = 16'd4;
    @(negedge clk);
    start = 1'b0;
    chk("wide_err", 32'(err), 32'd1);
    chk("wide_busy", 32'(busy), 32'd0);
    fill_ramp();
    push_n(4, 12'd80);
    run_frame(4, 4, 2'd1, 12'd0, 0, 0);
    chk("err_cleared", 32'(err), 32'd0);

    // Abort an 8x8 frame after 7 pixels.
    @(negedge clk);
    start = 1'b1; width = 16'd8; height = 16'd8; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 7 && cyc < 100) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(cnt * 7);
      #1;
      if (s_if.tready) cnt++;
      cyc++;
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    chk("abort_fed", 32'(cnt), 32'd7);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    fill_ramp();
    push_n(4, 12'd80);
    run_frame(4, 4, 2'd1, 12'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
